// File: rtl/keypad_key_decoder.sv
// Keypad key decoder: debounces the raw active-low key bitmap from the row scanner
// and turns it into press / release / auto-repeat events with multi-key lockout.
module keypad_key_decoder #(
  parameter int N            = 4,
  parameter int KW           = 4,
  parameter int DEBOUNCE     = 20,
  parameter int REPEAT_DELAY = 2500,
  parameter int REPEAT_RATE  = 500
) (
  input  logic              clk_5000hz,
  input  logic              rst,
  input  logic [N*N-1:0]    keyboard_in,
  output logic [KW-1:0]     key_code,
  output logic              key_valid,
  output logic              key_release,
  output logic              key_held,
  output logic              key_multi
);

  localparam int NK = N * N;
  localparam int CW = 8;
  localparam int TW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // True when exactly one key is down in the bitmap.
  function automatic logic is_single(input logic [NK-1:0] v);
    logic [NK-1:0] low_cleared;
    low_cleared = v & (v - NK'(1));
    return (v != '0) && (low_cleared == '0);
  endfunction

  function automatic logic [KW-1:0] bit_index(input logic [NK-1:0] v);
    logic [KW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NK; i++) begin
      if (v[i]) begin
        idx = KW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [NK-1:0] pressed_q, pressed_d;
  logic [NK-1:0] prev_q,    prev_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [TW-1:0] timer_q,   timer_d;
  state_t        state_q,   state_d;
  logic [KW-1:0] key_code_q,    key_code_d;
  logic          key_valid_q,   key_valid_d;
  logic          key_release_q, key_release_d;
  logic          key_held_q,    key_held_d;
  logic          key_multi_q,   key_multi_d;

  logic          stable_s;
  logic [NK-1:0] db_s;
  logic [NK-1:0] held_mask_s;

  // Sampling and the stable-run counter that qualifies a bitmap.
  always_comb begin
    pressed_d = ~keyboard_in;
    prev_d    = pressed_q;
    if (pressed_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    stable_s    = (cnt_q == CW'(DEBOUNCE));
    db_s        = prev_q;
    held_mask_s = NK'(1) << key_code_q;
  end

  // Event FSM; db_s is only consulted while stable_s holds.
  always_comb begin
    state_d       = state_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    key_held_d    = key_held_q;
    key_multi_d   = key_multi_q;
    timer_d       = timer_q;
    case (state_q)
      IDLE: begin
        if (stable_s && (db_s != '0)) begin
          if (is_single(db_s)) begin
            key_code_d  = bit_index(db_s);
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            timer_d     = TW'(REPEAT_DELAY);
            state_d     = HELD;
          end else begin
            key_multi_d = 1'b1;
            state_d     = LOCKED;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HELD: begin
        // Release is checked first so it beats a repeat expiring in the same cycle.
        if (stable_s && (db_s == '0)) begin
          key_release_d = 1'b1;
          key_held_d    = 1'b0;
          timer_d       = '0;
          state_d       = IDLE;
        end else if (stable_s && (db_s != held_mask_s)) begin
          key_held_d  = 1'b0;
          key_multi_d = 1'b1;
          timer_d     = '0;
          state_d     = LOCKED;
        end else if (REPEAT_DELAY != 0) begin
          if (timer_q <= TW'(1)) begin
            key_valid_d = 1'b1;
            timer_d     = TW'(REPEAT_RATE);
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end else begin
          timer_d = timer_q;
        end
      end
      LOCKED: begin
        if (stable_s && (db_s == '0)) begin
          key_multi_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        key_held_d  = 1'b0;
        key_multi_d = 1'b0;
        timer_d     = '0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_5000hz) begin
    if (rst) begin
      pressed_q     <= '0;
      prev_q        <= '0;
      cnt_q         <= '0;
      timer_q       <= '0;
      state_q       <= IDLE;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_held_q    <= 1'b0;
      key_multi_q   <= 1'b0;
    end else begin
      pressed_q     <= pressed_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      state_q       <= state_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
      key_held_q    <= key_held_d;
      key_multi_q   <= key_multi_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_release = key_release_q;
  assign key_held    = key_held_q;
  assign key_multi   = key_multi_q;

endmodule

// File: tb/tb_keypad_key_decoder.sv
// Bench for keypad_key_decoder: table of bitmap steps plus hand sequences,
// with pulse events checked against a cycle-stamped expectation queue.
module tb_keypad_key_decoder;

  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] kb_a, kb_b;
  logic [3:0]  a_code, b_code;
  logic        a_valid, a_rel, a_held, a_multi;
  logic        b_valid, b_rel, b_held, b_multi;

  keypad_key_decoder #(.N(4), .KW(4), .DEBOUNCE(DB), .REPEAT_DELAY(0), .REPEAT_RATE(1)) u_dut_a (
    .clk_5000hz(clk), .rst(rst), .keyboard_in(kb_a), .key_code(a_code),
    .key_valid(a_valid), .key_release(a_rel), .key_held(a_held), .key_multi(a_multi));

  keypad_key_decoder #(.N(4), .KW(4), .DEBOUNCE(DB), .REPEAT_DELAY(20), .REPEAT_RATE(10)) u_dut_b (
    .clk_5000hz(clk), .rst(rst), .keyboard_in(kb_b), .key_code(b_code),
    .key_valid(b_valid), .key_release(b_rel), .key_held(b_held), .key_multi(b_multi));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       rel;
    logic [3:0] code;
  } ev_t;

  typedef struct {
    logic [15:0] pressed;
    int          ev;
    logic [3:0]  code;
    logic        held;
    logic        multi;
    string       nm;
  } vec_t;

  ev_t  q_a[$];
  ev_t  q_b[$];
  vec_t vecs[11];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic expect_ev(input int d, input logic rel, input logic [3:0] c, input int at);
    ev_t e;
    e.cyc = at; e.rel = rel; e.code = c;
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic mon(input int d, input logic v, input logic r, input logic [3:0] c);
    ev_t e;
    int  sz;
    n_cmp++;
    if (v === 1'b1 && r === 1'b1) begin
      n_err++;
      $display("FAIL excl dut%0d cyc %0d: key_valid and key_release both 1, required not both", d, cyc);
    end
    sz = (d == 0) ? q_a.size() : q_b.size();
    while (sz > 0) begin
      e = (d == 0) ? q_a[0] : q_b[0];
      if (e.cyc >= cyc) break;
      n_cmp++; n_err++;
      $display("FAIL missed_event dut%0d cyc %0d: nothing seen, required rel=%0b code=%0d at cyc %0d",
               d, cyc, e.rel, e.code, e.cyc);
      if (d == 0) void'(q_a.pop_front());
      else        void'(q_b.pop_front());
      sz--;
    end
    if (v === 1'b1 || r === 1'b1) begin
      n_cmp++;
      if (sz == 0) begin
        n_err++;
        $display("FAIL unexpected_event dut%0d cyc %0d: got valid=%0b release=%0b code=%0d, required none",
                 d, cyc, v, r, c);
      end else begin
        e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
        if (e.cyc != cyc || e.rel !== r || e.code !== c) begin
          n_err++;
          $display("FAIL event dut%0d: got cyc %0d release=%0b code=%0d, required cyc %0d release=%0b code=%0d",
                   d, cyc, r, c, e.cyc, e.rel, e.code);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_valid, a_rel, a_code);
    mon(1, b_valid, b_rel, b_code);
  end

  task automatic chk(input int d, input string nm, input logic [3:0] c, input logic h, input logic m);
    logic [3:0] ac;
    logic       ah, am;
    ac = (d == 0) ? a_code  : b_code;
    ah = (d == 0) ? a_held  : b_held;
    am = (d == 0) ? a_multi : b_multi;
    n_cmp++;
    if (ac !== c || ah !== h || am !== m) begin
      n_err++;
      $display("FAIL %s dut%0d: got code=%0d held=%0b multi=%0b, required code=%0d held=%0b multi=%0b",
               nm, d, ac, ah, am, c, h, m);
    end
  endtask

  initial begin
    vecs[0]  = '{16'h0020, 1, 4'd5, 1'b1, 1'b0, "press5"};
    vecs[1]  = '{16'h0000, 2, 4'd5, 1'b0, 1'b0, "release5"};
    vecs[2]  = '{16'h0084, 0, 4'd5, 1'b0, 1'b1, "multi_2_7"};
    vecs[3]  = '{16'h0004, 0, 4'd5, 1'b0, 1'b1, "multi_drop7"};
    vecs[4]  = '{16'h0000, 0, 4'd5, 1'b0, 1'b0, "multi_clear"};
    vecs[5]  = '{16'h0008, 1, 4'd3, 1'b1, 1'b0, "press3"};
    vecs[6]  = '{16'h1008, 0, 4'd3, 1'b0, 1'b1, "second_key12"};
    vecs[7]  = '{16'h0000, 0, 4'd3, 1'b0, 1'b0, "second_clear"};
    vecs[8]  = '{16'h0001, 1, 4'd0, 1'b1, 1'b0, "press0"};
    vecs[9]  = '{16'h0200, 0, 4'd0, 1'b0, 1'b1, "swap_to9"};
    vecs[10] = '{16'h0000, 0, 4'd0, 1'b0, 1'b0, "swap_clear"};

    rst  = 1'b1;
    kb_a = 16'hFFFF;
    kb_b = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk(0, "reset", 4'd0, 1'b0, 1'b0);
    chk(1, "reset", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // Bounce on key 9 never stays put long enough to be accepted.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      kb_a = (((i / 3) % 2) == 0) ? 16'hFDFF : 16'hFFFF;
    end
    @(negedge clk);
    kb_a = 16'hFFFF;
    repeat (14) @(negedge clk);
    chk(0, "bounce", 4'd0, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      kb_a = ~vecs[i].pressed;
      if (vecs[i].ev != 0) expect_ev(0, vecs[i].ev == 2, vecs[i].code, cyc + DB + 3);
      repeat (14) @(negedge clk);
      chk(0, vecs[i].nm, vecs[i].code, vecs[i].held, vecs[i].multi);
    end

    // Auto-repeat on key 15: press at p, repeats at p+20/30/40/50, release at p+55.
    begin
      int p;
      @(negedge clk);
      kb_b = 16'h7FFF;
      p = cyc + DB + 3;
      expect_ev(1, 1'b0, 4'd15, p);
      expect_ev(1, 1'b0, 4'd15, p + 20);
      expect_ev(1, 1'b0, 4'd15, p + 30);
      expect_ev(1, 1'b0, 4'd15, p + 40);
      expect_ev(1, 1'b0, 4'd15, p + 50);
      repeat (30) @(negedge clk);
      chk(1, "repeat_held", 4'd15, 1'b1, 1'b0);
      repeat (25) @(negedge clk);
      kb_b = 16'hFFFF;
      expect_ev(1, 1'b1, 4'd15, cyc + DB + 3);
      repeat (30) @(negedge clk);
      chk(1, "repeat_after", 4'd15, 1'b0, 1'b0);
    end

    // Reset while key 4 is held: no release, then a fresh press once reset drops.
    @(negedge clk);
    kb_a = 16'hFFEF;
    expect_ev(0, 1'b0, 4'd4, cyc + DB + 3);
    repeat (14) @(negedge clk);
    chk(0, "hold4", 4'd4, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk(0, "rst_mid_hold", 4'd0, 1'b0, 1'b0);
    n_cmp++;
    if (a_valid !== 1'b0 || a_rel !== 1'b0) begin
      n_err++;
      $display("FAIL rst_pulses: got valid=%0b release=%0b, required 0 0", a_valid, a_rel);
    end
    expect_ev(0, 1'b0, 4'd4, cyc + DB + 3);
    repeat (14) @(negedge clk);
    chk(0, "rst_repress", 4'd4, 1'b1, 1'b0);
    kb_a = 16'hFFFF;
    expect_ev(0, 1'b1, 4'd4, cyc + DB + 3);
    repeat (14) @(negedge clk);
    chk(0, "rst_release", 4'd4, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    n_cmp++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_err++;
      $display("FAIL leftover_events: got %0d/%0d pending, required 0/0", q_a.size(), q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
